// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-code counter family: end-of-range mode
// encoding and width-agnostic Gray/binary conversion helpers.
package gray_pkg;

    // Widest counter the helpers support. Narrower values are zero-extended
    // on the way in and truncated on the way out.
    localparam int MAX_W = 32;

    // Behaviour at the end of the count range.
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;

    // Binary to Gray: each Gray bit is the XOR of neighbouring binary bits.
    // Zero-extended upper bits leave the result unchanged for narrow values.
    function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: prefix XOR running from the MSB downwards.
    function automatic logic [MAX_W-1:0] gray2bin(input logic [MAX_W-1:0] g);
        logic [MAX_W-1:0] b;
        logic             acc;
        b   = '0;
        acc = 1'b0;
        for (int i = MAX_W - 1; i >= 0; i--) begin
            acc  = acc ^ g[i];
            b[i] = acc;
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin_n.sv
// Combinational N-bit Gray to binary decoder.
module gray2bin_n #(
    parameter int N = 8
) (
    input  logic [N-1:0] gray_i,
    output logic [N-1:0] bin_o
);

    // Prefix XOR from the MSB: bin[i] = gray[N-1] ^ ... ^ gray[i].
    always_comb begin
        logic acc;
        bin_o = '0;
        acc   = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            acc      = acc ^ gray_i[i];
            bin_o[i] = acc;
        end
    end

endmodule

// File: rtl/gray_updown_counter.sv
// N-bit up/down Gray-code counter with parallel Gray load, wrap or saturate
// at the end of the range, terminal-count and one-cycle wrap status.
// The binary count is the primary state; the Gray output is a separate
// register fed from the encoded next count so it never glitches.
module gray_updown_counter
    import gray_pkg::*;
#(
    parameter int N        = 8,
    parameter int SATURATE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clk_en,
    input  logic         up_dn,
    input  logic         load,
    input  logic [N-1:0] load_val,
    output logic [N-1:0] gray_out,
    output logic [N-1:0] bin_out,
    output logic         tc,
    output logic         wrap
);

    localparam mode_e        MODE    = (SATURATE != 0) ? MODE_SAT : MODE_WRAP;
    localparam logic [N-1:0] CNT_MAX = '1;
    localparam logic [N-1:0] CNT_MIN = '0;

    logic [N-1:0] cnt_q,  cnt_d;
    logic [N-1:0] gray_q, gray_d;
    logic         wrap_q, wrap_d;

    logic [N-1:0] load_bin;
    logic [N-1:0] step_cnt;
    logic         step_wrap;

    // Binary image of the Gray load value.
    gray2bin_n #(
        .N (N)
    ) u_load_dec (
        .gray_i (load_val),
        .bin_o  (load_bin)
    );

    // One counting step in the requested direction, including the end-of-range
    // policy; a saturating hold simply leaves the count unchanged.
    always_comb begin
        step_cnt  = cnt_q;
        step_wrap = 1'b0;
        if (up_dn) begin
            if (cnt_q == CNT_MAX) begin
                if (MODE == MODE_WRAP) begin
                    step_cnt  = CNT_MIN;
                    step_wrap = 1'b1;
                end
            end else begin
                step_cnt = cnt_q + 1'b1;
            end
        end else begin
            if (cnt_q == CNT_MIN) begin
                if (MODE == MODE_WRAP) begin
                    step_cnt  = CNT_MAX;
                    step_wrap = 1'b1;
                end
            end else begin
                step_cnt = cnt_q - 1'b1;
            end
        end
    end

    // Next-state priority: load beats counting, counting beats hold.
    // Reset is applied in the register process and beats everything.
    always_comb begin
        cnt_d  = cnt_q;
        gray_d = gray_q;
        wrap_d = 1'b0;
        if (load) begin
            cnt_d  = load_bin;
            gray_d = load_val;
        end else if (clk_en) begin
            cnt_d  = step_cnt;
            gray_d = N'(bin2gray(MAX_W'(step_cnt)));
            wrap_d = step_wrap;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    // Terminal count follows the current count and direction without a clock.
    assign tc = up_dn ? (cnt_q == CNT_MAX) : (cnt_q == CNT_MIN);

    assign bin_out  = cnt_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;

endmodule
